my_serial_to_parallel: RTL and testbench

//  Receive end of the PISO serial link: shifts in one bit per enabled CLK, assembles N-bit

---
 rtl/my_serial_to_parallel_if.sv | 25 ++
 rtl/my_serial_to_parallel.sv | 94 +++++++++
 tb/tb_my_serial_to_parallel.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/my_serial_to_parallel_if.sv
// Bundle of bit-strobe, word handshake and status signals for the serial-to-parallel receiver.
interface my_serial_to_parallel_if #(
    parameter int N = 4
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic          en;
    logic          serial_in;
    logic          clr_ovr;
    logic          ready;
    logic [N-1:0]  datar;
    logic          valid;
    logic          overrun;
    logic [CW-1:0] bit_cnt;

    modport master (
        output en, serial_in, clr_ovr, ready,
        input  datar, valid, overrun, bit_cnt
    );

    modport slave (
        input  en, serial_in, clr_ovr, ready,
        output datar, valid, overrun, bit_cnt
    );
endinterface

// File: rtl/my_serial_to_parallel.sv
// Receive end of the PISO link: shifts in one bit per enabled clock, assembles N-bit words
// and offers each on datar with a valid/ready handshake; sticky overrun flags dropped words.
module my_serial_to_parallel #(
    parameter int N         = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    my_serial_to_parallel_if.slave bus
);
    localparam int            CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [N-1:0]  shift_r;
    logic [N-1:0]  shift_s;
    logic [N-1:0]  word_s;
    logic [N-1:0]  datar_r;
    logic [N-1:0]  datar_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic          valid_r;
    logic          valid_s;
    logic          overrun_r;
    logic          overrun_s;
    logic          complete_s;

    // Serial side: word assembly including the bit arriving on this edge
    always_comb begin
        if (MSB_FIRST) begin
            word_s = {shift_r[N-2:0], bus.serial_in};
        end else begin
            word_s = {bus.serial_in, shift_r[N-1:1]};
        end
        complete_s = bus.en && (cnt_r == LAST);
        shift_s    = shift_r;
        cnt_s      = cnt_r;
        if (bus.en) begin
            shift_s = word_s;
            if (complete_s) begin
                cnt_s = {CW{1'b0}};
            end else begin
                cnt_s = cnt_r + CW'(1);
            end
        end else begin
            shift_s = shift_r;
            cnt_s   = cnt_r;
        end
    end

    // Consumer side: handshake and sticky overrun; a set on the same edge beats clr_ovr
    always_comb begin
        datar_s = datar_r;
        valid_s = valid_r;
        if (bus.clr_ovr) begin
            overrun_s = 1'b0;
        end else begin
            overrun_s = overrun_r;
        end
        if (complete_s) begin
            if (valid_r && !bus.ready) begin
                overrun_s = 1'b1;
            end else begin
                datar_s = word_s;
                valid_s = 1'b1;
            end
        end else if (valid_r && bus.ready) begin
            valid_s = 1'b0;
        end else begin
            valid_s = valid_r;
        end
    end

    // State registers with asynchronous reset discarding any partial word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_r   <= {N{1'b0}};
            cnt_r     <= {CW{1'b0}};
            datar_r   <= {N{1'b0}};
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            shift_r   <= shift_s;
            cnt_r     <= cnt_s;
            datar_r   <= datar_s;
            valid_r   <= valid_s;
            overrun_r <= overrun_s;
        end
    end

    assign bus.datar   = datar_r;
    assign bus.valid   = valid_r;
    assign bus.overrun = overrun_r;
    assign bus.bit_cnt = cnt_r;
endmodule

// File: tb/tb_my_serial_to_parallel.sv
// Bench for my_serial_to_parallel: LSB-first and MSB-first instances share one stimulus stream
// and are checked every cycle against a word-level model plus literal expectations.
module tb_my_serial_to_parallel;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    my_serial_to_parallel_if #(.N(N)) bus0 ();
    my_serial_to_parallel_if #(.N(N)) bus1 ();

    my_serial_to_parallel #(.N(N), .MSB_FIRST(1'b0)) dut_lsb (.clk(clk), .rst(rst), .bus(bus0));
    my_serial_to_parallel #(.N(N), .MSB_FIRST(1'b1)) dut_msb (.clk(clk), .rst(rst), .bus(bus1));

    assign bus1.en        = bus0.en;
    assign bus1.serial_in = bus0.serial_in;
    assign bus1.clr_ovr   = bus0.clr_ovr;
    assign bus1.ready     = bus0.ready;

    // Word-level model: bit k of a word lands at index k (LSB-first) or N-1-k (MSB-first)
    int         m_cnt   = 0;
    logic [3:0] m_acc0  = 4'd0;
    logic [3:0] m_acc1  = 4'd0;
    logic [3:0] m_d0    = 4'd0;
    logic [3:0] m_d1    = 4'd0;
    logic       m_valid = 1'b0;
    logic       m_ovr   = 1'b0;

    always @(posedge clk or posedge rst) begin : model
        logic       c;
        logic       nv_ovr;
        logic [3:0] a0;
        logic [3:0] a1;
        if (rst) begin
            m_cnt   <= 0;
            m_acc0  <= 4'd0;
            m_acc1  <= 4'd0;
            m_d0    <= 4'd0;
            m_d1    <= 4'd0;
            m_valid <= 1'b0;
            m_ovr   <= 1'b0;
        end else begin
            a0 = m_acc0;
            a1 = m_acc1;
            c  = bus0.en && (m_cnt == N - 1);
            if (bus0.en) begin
                a0[m_cnt]         = bus0.serial_in;
                a1[N - 1 - m_cnt] = bus0.serial_in;
                m_cnt  <= c ? 0 : m_cnt + 1;
                m_acc0 <= c ? 4'd0 : a0;
                m_acc1 <= c ? 4'd0 : a1;
            end
            nv_ovr = bus0.clr_ovr ? 1'b0 : m_ovr;
            if (c) begin
                if (m_valid && !bus0.ready) begin
                    nv_ovr = 1'b1;
                end else begin
                    m_d0    <= a0;
                    m_d1    <= a1;
                    m_valid <= 1'b1;
                end
            end else if (m_valid && bus0.ready) begin
                m_valid <= 1'b0;
            end
            m_ovr <= nv_ovr;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        check("datar_lsb", 32'(bus0.datar), 32'(m_d0));
        check("datar_msb", 32'(bus1.datar), 32'(m_d1));
        check("valid_lsb", 32'(bus0.valid), 32'(m_valid));
        check("valid_msb", 32'(bus1.valid), 32'(m_valid));
        check("ovr_lsb", 32'(bus0.overrun), 32'(m_ovr));
        check("ovr_msb", 32'(bus1.overrun), 32'(m_ovr));
        check("cnt_lsb", 32'(bus0.bit_cnt), 32'(m_cnt));
        check("cnt_msb", 32'(bus1.bit_cnt), 32'(m_cnt));
    end

    task automatic send_bit(input logic b);
        bus0.en        = 1'b1;
        bus0.serial_in = b;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus0.en        = 1'b0;
        bus0.serial_in = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_word(input logic [3:0] w, input bit msbf);
        for (int i = 0; i < 4; i++) begin
            send_bit(msbf ? w[3 - i] : w[i]);
        end
    endtask

    logic [3:0] tbl [4] = '{4'b0000, 4'b0001, 4'b0100, 4'b1111};

    initial begin
        bus0.en        = 1'b0;
        bus0.serial_in = 1'b0;
        bus0.clr_ovr   = 1'b0;
        bus0.ready     = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_datar", 32'(bus0.datar), 32'd0);
        check("rst_valid", 32'(bus0.valid), 32'd0);

        // Reset mid-word, then 1,0,1,1
        send_bit(1'b1);
        send_bit(1'b0);
        bus0.en = 1'b0;
        check("t1_cnt_pre", 32'(bus0.bit_cnt), 32'd2);
        #2 rst = 1'b1;
        #1 check("t1_rst_cnt", 32'(bus0.bit_cnt), 32'd0);
        check("t1_rst_datar", 32'(bus0.datar), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send_word(4'b1101, 1'b0);
        check("t1_datar", 32'(bus0.datar), 32'b1101);
        check("t1_valid", 32'(bus0.valid), 32'd1);
        check("t1_cnt", 32'(bus0.bit_cnt), 32'd0);
        bus0.ready = 1'b1;
        idle(1);
        check("t1_consumed", 32'(bus0.valid), 32'd0);
        bus0.ready = 1'b0;

        // Gapped enable
        send_bit(1'b0); idle(3);
        check("t2_cnt1", 32'(bus0.bit_cnt), 32'd1);
        send_bit(1'b1); idle(3);
        check("t2_cnt2", 32'(bus0.bit_cnt), 32'd2);
        send_bit(1'b0); idle(3);
        send_bit(1'b0);
        check("t2_datar", 32'(bus0.datar), 32'b0010);
        bus0.ready = 1'b1;
        idle(1);

        // Continuous words with ready high
        send_word(4'b1111, 1'b0);
        check("t3_datar_a", 32'(bus0.datar), 32'b1111);
        check("t3_valid_a", 32'(bus0.valid), 32'd1);
        send_word(4'b0000, 1'b0);
        check("t3_datar_b", 32'(bus0.datar), 32'b0000);
        check("t3_ovr", 32'(bus0.overrun), 32'd0);
        idle(1);

        // True back-to-back: ready rises exactly on the completing edge of the next word
        bus0.ready = 1'b0;
        send_word(4'b1010, 1'b0);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        bus0.ready = 1'b1;
        send_bit(1'b0);
        check("t3_b2b_datar", 32'(bus0.datar), 32'b0110);
        check("t3_b2b_valid", 32'(bus0.valid), 32'd1);
        check("t3_b2b_ovr", 32'(bus0.overrun), 32'd0);
        idle(1);
        bus0.ready = 1'b0;

        // Overrun and clear
        send_word(4'b0001, 1'b0);
        send_word(4'b0100, 1'b0);
        check("t4_datar", 32'(bus0.datar), 32'b0001);
        check("t4_ovr", 32'(bus0.overrun), 32'd1);
        bus0.ready = 1'b1;
        idle(1);
        check("t4_valid", 32'(bus0.valid), 32'd0);
        check("t4_ovr_hold", 32'(bus0.overrun), 32'd1);
        bus0.ready   = 1'b0;
        bus0.clr_ovr = 1'b1;
        idle(1);
        bus0.clr_ovr = 1'b0;
        check("t4_clr", 32'(bus0.overrun), 32'd0);

        // Set beats clear on the same edge
        send_word(4'b0011, 1'b0);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
        bus0.clr_ovr = 1'b1;
        send_bit(1'b1);
        bus0.clr_ovr = 1'b0;
        check("t4_setwins", 32'(bus0.overrun), 32'd1);
        check("t4_setwins_d", 32'(bus0.datar), 32'b0011);
        bus0.ready   = 1'b1;
        bus0.clr_ovr = 1'b1;
        idle(1);
        bus0.clr_ovr = 1'b0;
        check("t4_final_ovr", 32'(bus0.overrun), 32'd0);

        // Loopback order as produced by the transmitter
        for (int k = 0; k < 4; k++) begin
            send_word(tbl[k], 1'b0);
            check($sformatf("t5_loop%0d", k), 32'(bus0.datar), 32'(tbl[k]));
        end
        idle(1);
        send_word(4'b1101, 1'b1);
        check("t5_msb", 32'(bus1.datar), 32'b1101);
        check("t5_msb_on_lsb", 32'(bus0.datar), 32'b1011);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
